// File: rtl/base0_pkg.sv
// base0_pkg
//   Shared definitions for the base0 sprite pipeline.
//   - SCREEN_W / SCREEN_H : visible screen size in pixels
//   - DEF_BASE_X / DEF_BASE_Y : default top-left corner of the base0 sprite window
//   - DEF_TRANSP_IDX : palette index that marks a transparent sprite pixel
//   - coord_t        : 10-bit scan coordinate
//   - flash_state_e  : states of the optional hit-flash FSM
package base0_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [9:0] coord_t;

    localparam coord_t     DEF_BASE_X     = 10'd304;
    localparam coord_t     DEF_BASE_Y     = 10'd448;
    localparam logic [7:0] DEF_TRANSP_IDX = 8'd0;

    typedef enum logic {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_e;

endpackage

// File: rtl/base0_sync_delay.sv
// base0_sync_delay
//   Fixed-depth shift delay whose stages clear to a per-bit reset value, so a
//   mix of active-high and active-low signals all come out inactive after reset.
//   Parameters: WIDTH (bits carried), DEPTH (clocks of delay, >=1), RST_VAL.
//   Ports:
//     clk      in   1       clock
//     reset_n  in   1       asynchronous active-low reset
//     din      in   WIDTH   signals to delay
//     dout     out  WIDTH   din delayed by DEPTH clocks
module base0_sync_delay #(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    // NOTE: every stage is reset (not just the last) so that no pre-reset
    // value can ripple out after release; a plain data RAM would not need this.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= RST_VAL;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, giving a true shift rather than a
            // single-cycle fall-through.
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/base0_index_fetch.sv
// base0_index_fetch
//   Upstream stage of the base0 palette lookup. Decides whether the scan
//   position lies in the base0 sprite window, drives the sprite ROM address,
//   and returns the palette index plus an opaque-coverage flag. hs/vs/de are
//   delayed to stay aligned with the index. Total latency L = ROM_LAT+2.
//   Optional hit-flash (blink) effect: define BASE0_FLASH_EN.
//   Ports:
//     clk        in   1               pixel clock
//     reset_n    in   1               asynchronous active-low reset
//     draw_x     in   10              current scan column
//     draw_y     in   10              current scan row
//     de         in   1               active video
//     hs, vs     in   1               syncs, active low
//     hit        in   1               one-clock pulse: base was struck
//     rom_addr   out  W_LOG2+H_LOG2   sprite ROM address (registered)
//     rom_q      in   8               ROM data, ROM_LAT clocks after rom_addr
//     index      out  8               palette index
//     sprite_on  out  1               index is an opaque, visible sprite pixel
//     de_out, hs_out, vs_out  out 1   inputs delayed by L
module base0_index_fetch
    import base0_pkg::*;
#(
    parameter coord_t     BASE_X       = DEF_BASE_X,
    parameter coord_t     BASE_Y       = DEF_BASE_Y,
    parameter int         W_LOG2       = 5,
    parameter int         H_LOG2       = 5,
    parameter int         ROM_LAT      = 1,
    parameter logic [7:0] TRANSP_IDX   = DEF_TRANSP_IDX,
    parameter logic [5:0] FLASH_FRAMES = 6'd48
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [9:0]               draw_x,
    input  logic [9:0]               draw_y,
    input  logic                     de,
    input  logic                     hs,
    input  logic                     vs,
    input  logic                     hit,
    output logic [W_LOG2+H_LOG2-1:0] rom_addr,
    input  logic [7:0]               rom_q,
    output logic [7:0]               index,
    output logic                     sprite_on,
    output logic                     de_out,
    output logic                     hs_out,
    output logic                     vs_out
);

    // Window bounds in 11 bits so BASE + size cannot wrap past 1023.
    localparam logic [10:0] X_LO = {1'b0, BASE_X};
    localparam logic [10:0] X_HI = X_LO + 11'(1 << W_LOG2);
    localparam logic [10:0] Y_LO = {1'b0, BASE_Y};
    localparam logic [10:0] Y_HI = Y_LO + 11'(1 << H_LOG2);

    // ---------------- Stage 0: window test and ROM address ----------------
    logic              in_win;
    logic [W_LOG2-1:0] dx;
    logic [H_LOG2-1:0] dy;

    always_comb begin
        in_win = de
              && ({1'b0, draw_x} >= X_LO) && ({1'b0, draw_x} < X_HI)
              && ({1'b0, draw_y} >= Y_LO) && ({1'b0, draw_y} < Y_HI);
    end

    // Only the low bits of the offset matter; inside the window they are exact.
    assign dx = draw_x[W_LOG2-1:0] - BASE_X[W_LOG2-1:0];
    assign dy = draw_y[H_LOG2-1:0] - BASE_Y[H_LOG2-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
        end else begin
            rom_addr <= in_win ? {dy, dx} : '0;
        end
    end

    // ------------- Control delay matching address reg + ROM ---------------
    logic in_win_d, de_d, hs_d, vs_d;

    base0_sync_delay #(
        .WIDTH   (4),
        .DEPTH   (ROM_LAT + 1),
        .RST_VAL (4'b0011)          // in_win, de clear to 0; hs, vs idle high
    ) u_sync_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({in_win, de, hs, vs}),
        .dout    ({in_win_d, de_d, hs_d, vs_d})
    );

    // ------------------------- Optional hit flash -------------------------
    logic blank_now;

`ifdef BASE0_FLASH_EN
    flash_state_e state, state_next;
    logic [5:0]   frame_cnt, frame_cnt_next;
    logic         vs_q;
    logic         frame_tick;

    // vs is active low: a frame starts where it falls.
    assign frame_tick = vs_q && !vs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            frame_cnt <= '0;
            vs_q      <= 1'b1;
        end else begin
            state     <= state_next;
            frame_cnt <= frame_cnt_next;
            vs_q      <= vs;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        state_next     = state;
        frame_cnt_next = frame_cnt;
        if (hit) begin
            // A hit restarts the effect and takes priority over a tick.
            state_next     = FLASH;
            frame_cnt_next = '0;
        end else if (state == FLASH && frame_tick) begin
            if (frame_cnt == FLASH_FRAMES - 6'd1) begin
                state_next     = IDLE;
                frame_cnt_next = '0;
            end else begin
                frame_cnt_next = frame_cnt + 6'd1;
            end
        end
    end

    // Hidden for 4 frames, shown for 4 frames while flashing.
    assign blank_now = (state == FLASH) && frame_cnt[2];
`else
    logic unused_flash;
    assign unused_flash = ^{hit, FLASH_FRAMES};
    assign blank_now    = 1'b0;
`endif

    // ---------------------------- Output stage ----------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index     <= TRANSP_IDX;
            sprite_on <= 1'b0;
            de_out    <= 1'b0;
            hs_out    <= 1'b1;
            vs_out    <= 1'b1;
        end else begin
            index     <= in_win_d ? rom_q : TRANSP_IDX;
            sprite_on <= in_win_d && (rom_q != TRANSP_IDX) && !blank_now;
            de_out    <= de_d;
            hs_out    <= hs_d;
            vs_out    <= vs_d;
        end
    end

endmodule

// File: tb/tb_base0_index_fetch.sv
// tb_base0_index_fetch
//   Drives two instances of base0_index_fetch (ROM_LAT=1 -> L=3, ROM_LAT=2 ->
//   L=4) with the same scan stimulus. Each has its own sprite ROM model.
//   Expected outputs are pushed to a per-instance queue as each pixel is
//   driven and popped when the latency has elapsed. Honours BASE0_FLASH_EN.
module tb_base0_index_fetch;
    import base0_pkg::*;

    typedef struct packed {
        logic [7:0] index;
        logic       sprite_on;
        logic       de;
        logic       hs;
        logic       vs;
    } out_t;

    localparam out_t IDLE_OUT = '{index: 8'h00, sprite_on: 1'b0, de: 1'b0, hs: 1'b1, vs: 1'b1};
    localparam int   L1 = 3;
    localparam int   L2 = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] draw_x, draw_y;
    logic       de, hs, vs, hit;

    logic [9:0] rom1_addr, rom2_addr;
    logic [7:0] rom1_q = 8'h00;
    logic [7:0] rom2_s = 8'h00;
    logic [7:0] rom2_q = 8'h00;
    logic [7:0] index1, index2;
    logic       spr1, spr2, de1, de2, hs1, hs2, vs1, vs2;

    int n_cmp = 0;
    int n_bad = 0;

    out_t q1[$];
    out_t q2[$];

    always #5 clk = ~clk;

    // Sprite ROM contents: address 0 holds 4, address {3,3} is transparent.
    function automatic logic [7:0] rom_val(input logic [9:0] a);
        if (a == 10'h000) return 8'h04;
        if (a == 10'h063) return 8'h00;
        return a[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk) rom1_q <= rom_val(rom1_addr);
    always @(posedge clk) begin
        rom2_s <= rom_val(rom2_addr);
        rom2_q <= rom2_s;
    end

    base0_index_fetch #(.ROM_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y),
        .de(de), .hs(hs), .vs(vs), .hit(hit),
        .rom_addr(rom1_addr), .rom_q(rom1_q), .index(index1), .sprite_on(spr1),
        .de_out(de1), .hs_out(hs1), .vs_out(vs1)
    );

    base0_index_fetch #(.ROM_LAT(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y),
        .de(de), .hs(hs), .vs(vs), .hit(hit),
        .rom_addr(rom2_addr), .rom_q(rom2_q), .index(index2), .sprite_on(spr2),
        .de_out(de2), .hs_out(hs2), .vs_out(vs2)
    );

    // ---------------- Flash reference model ----------------
    logic       m_flash;
    logic [5:0] m_cnt;
    logic       m_prev_vs;

    task automatic model_reset();
        m_flash   = 1'b0;
        m_cnt     = 6'd0;
        m_prev_vs = 1'b1;
    endtask

    function automatic logic model_blank();
`ifdef BASE0_FLASH_EN
        return m_flash && m_cnt[2];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_update(input logic ht, input logic v);
`ifdef BASE0_FLASH_EN
        logic tick;
        tick = m_prev_vs && !v;
        if (ht) begin
            m_flash = 1'b1;
            m_cnt   = 6'd0;
        end else if (m_flash && tick) begin
            if (m_cnt == 6'd47) m_flash = 1'b0;
            else                m_cnt   = m_cnt + 6'd1;
        end
`endif
        m_prev_vs = v;
    endtask

    // ---------------- Checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One pixel clock: drive inputs, record expectations, clock, compare.
    task automatic step(input logic [9:0] x, input logic [9:0] y,
                        input logic d, input logic h, input logic v, input logic ht);
        out_t       e, e1, e2;
        logic       win, blank_before;
        logic [9:0] a;
        draw_x = x; draw_y = y; de = d; hs = h; vs = v; hit = ht;
        win = d && x >= 10'd304 && x < 10'd336 && y >= 10'd448 && y < 10'd480;
        a   = win ? {5'(y - 10'd448), 5'(x - 10'd304)} : 10'd0;
        e.index     = win ? rom_val(a) : 8'h00;
        e.sprite_on = win && (rom_val(a) != 8'h00);
        e.de = d; e.hs = h; e.vs = v;
        q1.push_back(e);
        q2.push_back(e);
        // The output register sees the flash state as it stood before this edge.
        blank_before = model_blank();
        model_update(ht, v);
        @(posedge clk);
        #1;
        check("rom_addr_lat1", {22'd0, rom1_addr}, {22'd0, a});
        check("rom_addr_lat2", {22'd0, rom2_addr}, {22'd0, a});
        if (q1.size() == L1) begin
            e1 = q1.pop_front();
            e1.sprite_on = e1.sprite_on && !blank_before;
        end else begin
            e1 = IDLE_OUT;
        end
        if (q2.size() == L2) begin
            e2 = q2.pop_front();
            e2.sprite_on = e2.sprite_on && !blank_before;
        end else begin
            e2 = IDLE_OUT;
        end
        check("out_L3", {20'd0, index1, spr1, de1, hs1, vs1}, {20'd0, e1});
        check("out_L4", {20'd0, index2, spr2, de2, hs2, vs2}, {20'd0, e2});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_1"}, {19'd0, rom1_addr, index1, spr1, de1, hs1, vs1}, {19'd0, 10'd0, IDLE_OUT});
        check({tag, "_2"}, {19'd0, rom2_addr, index2, spr2, de2, hs2, vs2}, {19'd0, 10'd0, IDLE_OUT});
    endtask

    initial begin
        reset_n = 1'b0;
        draw_x = '0; draw_y = '0; de = 1'b0; hs = 1'b1; vs = 1'b1; hit = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset_initial");
        @(negedge clk);
        reset_n = 1'b1;

        // Origin pixel: address 0, index 4 after L clocks.
        step(10'd304, 10'd448, 1'b1, 1'b1, 1'b1, 1'b0);
        step(10'd305, 10'd448, 1'b1, 1'b1, 1'b1, 1'b0);
        step(10'd100, 10'd100, 1'b0, 1'b1, 1'b1, 1'b0);

        // Window edges.
        step(10'd303, 10'd450, 1'b1, 1'b1, 1'b1, 1'b0);
        step(10'd336, 10'd450, 1'b1, 1'b1, 1'b1, 1'b0);
        step(10'd335, 10'd450, 1'b1, 1'b1, 1'b1, 1'b0);
        step(10'd304, 10'd479, 1'b1, 1'b1, 1'b1, 1'b0);
        step(10'd304, 10'd480, 1'b1, 1'b1, 1'b1, 1'b0);
        step(10'd320, 10'd447, 1'b1, 1'b1, 1'b1, 1'b0);
        step(10'd335, 10'd479, 1'b1, 1'b1, 1'b1, 1'b0);

        // Transparent ROM entry, then de=0 inside the window.
        step(10'd307, 10'd451, 1'b1, 1'b1, 1'b1, 1'b0);
        step(10'd310, 10'd455, 1'b0, 1'b1, 1'b1, 1'b0);
        step(10'd310, 10'd455, 1'b1, 1'b1, 1'b1, 1'b0);

        // Scan of the lower part of an 800-wide frame, through vsync.
        for (int y = 440; y < 486; y++) begin
            for (int x = 0; x < 800; x++) begin
                step(10'(x), 10'(y), (x < 640) && (y < 480),
                     !(x >= 656 && x < 752), !(y >= 482 && y < 484), 1'b0);
            end
        end

        // Asynchronous reset in the middle of a sprite line.
        for (int x = 300; x <= 320; x++) begin
            step(10'(x), 10'd460, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("reset_midline");
        q1.delete();
        q2.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int x = 321; x < 336; x++) begin
            step(10'(x), 10'd460, 1'b1, 1'b1, 1'b1, 1'b0);
        end

        // Hit flash: short frames, each opening with a vsync pulse.
        step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int f = 0; f < 64; f++) begin
            step(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            step(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 8; i++) begin
                step(10'(304 + i), 10'd448, 1'b1, 1'b1, 1'b1, (f == 10) && (i == 0));
            end
        end

        // Drain the pipelines.
        for (int i = 0; i < L2; i++) begin
            step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
